// File: rtl/tx_fsm_pkg.sv
// Shared types and constants for the stop-and-wait transmit block.
//   state_t      : transmit FSM states
//   WR_EN..FAIL  : bit positions on uio_in / uio_out
//   UIO_OE       : fixed bidirectional-pin direction mask (7:4 out, 3:0 in)
package tx_fsm_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAIT  = 2'd2,
    ERROR = 2'd3
  } state_t;

  // uio_in bit positions
  localparam int unsigned WR_EN    = 0;
  localparam int unsigned ACK      = 1;
  localparam int unsigned NACK     = 2;
  // uio_out bit positions
  localparam int unsigned SEQ      = 3;
  localparam int unsigned TX_VALID = 4;
  localparam int unsigned FULL     = 5;
  localparam int unsigned EMPTY    = 6;
  localparam int unsigned FAIL     = 7;

  localparam logic [7:0] UIO_OE = 8'hF0;

endpackage

// File: rtl/tt_um_tx_fsm.sv
// Tiny Tapeout wrapper: wires the standard user-project pins straight to tx_fsm.
//   clk, rst_n, ena, ui_in, uio_in : standard TT inputs
//   uo_out, uio_out, uio_oe        : standard TT outputs
module tt_um_tx_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  tx_fsm u_tx_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

endmodule

// File: rtl/tx_fsm_fifo.sv
// Synchronous first-word-fall-through FIFO holding bytes awaiting transmission.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write strobe and data (ignored while full)
//   pop        : remove head entry (ignored while empty)
//   dout       : current head entry
//   full/empty : registered occupancy flags
module tx_fsm_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  // Gate on the registered flags, so a pop never frees a slot for a same-cycle push.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count_d = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign dout    = mem[rd_ptr];

  // Pointers, count and flags; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tx_fsm.sv
// Byte transmit path with stop-and-wait ARQ: queues bytes, presents the head
// byte with a one-cycle tx_valid strobe, retransmits on NACK/timeout and drops
// the byte (setting sticky fail) once retries are exhausted.
//   clk, rst_n : clock, async active-low reset
//   ena        : design select, unused
//   ui_in      : byte to push
//   uio_in     : [0] wr_en, [1] ack, [2] nack
//   uo_out     : transmit data register
//   uio_out    : [3] seq, [4] tx_valid, [5] fifo_full, [6] fifo_empty, [7] fail
//   uio_oe     : constant 8'hF0
// Optional: define TX_FSM_SEQ_BIT_EN to drive an alternating sequence bit on
// uio_out[3]; otherwise that bit is tied to 0.
module tx_fsm
  import tx_fsm_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state_q, state_d;
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                fail_q, fail_d;
  logic                tx_valid_q, tx_valid_d;
  logic                pop_c;
  logic                seq_bit;

  logic [DATA_W-1:0]   fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;

  logic                wr_en;
  logic                ack;
  logic                nack;
  logic                unused_pins;

  assign wr_en       = uio_in[WR_EN];
  assign ack         = uio_in[ACK];
  assign nack        = uio_in[NACK];
  assign unused_pins = &{1'b0, ena, uio_in[7:3]};

  tx_fsm_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (pop_c),
    .din   (ui_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, counters and pop strobe.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    fail_d  = fail_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        // Head byte is only copied here; it leaves the FIFO on ACK or drop.
        if (!fifo_empty) begin
          data_d  = fifo_dout;
          state_d = SEND;
        end
      end
      SEND: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (ack) begin
          pop_c   = 1'b1;
          retry_d = '0;
          state_d = IDLE;
        end else if (nack || (tmo_q == TMO_W'(TIMEOUT - 1))) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = SEND;
          end else begin
            state_d = ERROR;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ERROR: begin
        pop_c   = 1'b1;
        retry_d = '0;
        fail_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // tx_valid is registered so it is high exactly while the FSM sits in SEND.
  assign tx_valid_d = (state_d == SEND);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      retry_q    <= '0;
      tmo_q      <= '0;
      data_q     <= '0;
      fail_q     <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      data_q     <= data_d;
      fail_q     <= fail_d;
      tx_valid_q <= tx_valid_d;
    end
  end

`ifdef TX_FSM_SEQ_BIT_EN
  logic seq_q;

  // Alternates once per byte leaving the FIFO; steady across retransmissions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= 1'b0;
    end else if (pop_c) begin
      seq_q <= ~seq_q;
    end
  end

  assign seq_bit = seq_q;
`else
  assign seq_bit = 1'b0;
`endif

  // Pin mapping.
  always_comb begin
    uio_out           = '0;
    uio_out[SEQ]      = seq_bit;
    uio_out[TX_VALID] = tx_valid_q;
    uio_out[FULL]     = fifo_full;
    uio_out[EMPTY]    = fifo_empty;
    uio_out[FAIL]     = fail_q;
  end

  assign uo_out = data_q;
  assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_tx_fsm.sv
// Bench for tx_fsm: directed scenarios plus randomized traffic, checked against
// a transaction-level model (byte queue, per-byte attempt count, sticky fail,
// sequence bit).
module tb_tx_fsm;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned TIMEOUT   = 16;

`ifdef TX_FSM_SEQ_BIT_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena   = 1'b1;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  tx_fsm #(
    .DEPTH     (DEPTH),
    .MAX_RETRY (MAX_RETRY),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tx_count = 0;
  int tx_cyc   = 0;
  bit tx_seen  = 1'b0;

  // Reference model
  byte unsigned q[$];
  int  tries       = 0;
  int  exp_tx      = 0;
  bit  fail_m      = 1'b0;
  bit  seq_m       = 1'b0;
  bit  prev_none   = 1'b0;
  int  prev_tx_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and note any tx_valid strobe.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (uio_out[4] === 1'b1) begin
      tx_seen = 1'b1;
      tx_cyc  = cyc;
      tx_count++;
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_full"},  32'(uio_out[5]), 32'(q.size() == DEPTH));
    chk({tag, "_empty"}, 32'(uio_out[6]), 32'(q.size() == 0));
    chk({tag, "_fail"},  32'(uio_out[7]), 32'(fail_m));
    chk({tag, "_seq"},   32'(uio_out[3]), 32'(SEQ_EN ? seq_m : 1'b0));
    chk({tag, "_low"},   32'(uio_out[2:0]), 32'd0);
  endtask

  task automatic push(input byte unsigned b);
    ui_in     = b;
    uio_in[0] = 1'b1;
    tick();
    uio_in[0] = 1'b0;
    if (q.size() < DEPTH) q.push_back(b);
    chk("push_full",  32'(uio_out[5]), 32'(q.size() == DEPTH));
    chk("push_empty", 32'(uio_out[6]), 32'(q.size() == 0));
  endtask

  task automatic wait_tx();
    int n = 0;
    while (!tx_seen && n < 200) begin
      tick();
      n++;
    end
    chk("tx_seen", 32'(tx_seen), 32'd1);
    tx_seen = 1'b0;
  endtask

  task automatic drop();
    void'(q.pop_front());
    tries  = 0;
    fail_m = 1'b1;
    seq_m  = ~seq_m;
  endtask

  // One transmit attempt of the head byte. resp: 0 ack, 1 nack, 2 silence, 3 ack+nack.
  task automatic attempt(input int resp);
    int d;
    wait_tx();
    exp_tx++;
    chk("tx_data", 32'(uo_out), 32'(q[0]));
    if (prev_none) chk("tmo_gap", 32'(tx_cyc - prev_tx_cyc), 32'(TIMEOUT + 1));
    prev_tx_cyc = tx_cyc;
    prev_none   = (resp == 2);
    if (resp == 2) begin
      if (tries < MAX_RETRY) begin
        tries++;
      end else begin
        repeat (TIMEOUT + 2) tick();
        drop();
        prev_none = 1'b0;
        chk_flags("drop_tmo");
      end
    end else begin
      if (cyc == tx_cyc) begin
        tick();
        d = $urandom_range(0, 11);
        repeat (d) tick();
      end
      uio_in[1] = (resp != 1);
      uio_in[2] = (resp != 0);
      tick();
      uio_in[2:1] = 2'b00;
      if (resp != 1) begin
        void'(q.pop_front());
        tries = 0;
        seq_m = ~seq_m;
        chk_flags("ack");
      end else if (tries < MAX_RETRY) begin
        tries++;
        chk_flags("nack");
      end else begin
        tick();
        drop();
        chk_flags("drop_nack");
      end
    end
  endtask

  initial begin
    int k;
    int r;

    // Reset held with toggling inputs
    #2 rst_n = 1'b0;
    #1;
    chk("rst_uo", 32'(uo_out), 32'h00);
    chk("rst_uio", 32'(uio_out), 32'h40);
    chk("rst_oe", 32'(uio_oe), 32'hF0);
    for (int i = 0; i < 5; i++) begin
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      ena    = 1'($urandom);
      tick();
      chk("rst_hold_uo", 32'(uo_out), 32'h00);
      chk("rst_hold_uio", 32'(uio_out), 32'h40);
    end
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;
    rst_n  = 1'b1;
    tick();
    chk_flags("post_rst");

    // ACK/NACK while idle are ignored
    uio_in[2:1] = 2'b11;
    repeat (3) tick();
    uio_in[2:1] = 2'b00;
    tick();
    chk_flags("idle_resp");
    chk("idle_uo", 32'(uo_out), 32'h00);

    // Single byte
    push(8'hA5);
    attempt(0);
    repeat (3) tick();
    chk("single_tx", 32'(tx_count), 32'(exp_tx));
    chk("single_uo", 32'(uo_out), 32'hA5);

    // Two NACKs then ACK
    push(8'h3C);
    attempt(1);
    attempt(1);
    attempt(0);
    repeat (3) tick();
    chk("nack_tx", 32'(tx_count), 32'(exp_tx));

    // Silent receiver: four attempts then drop
    push(8'h55);
    for (int i = 0; i < 4; i++) attempt(2);
    chk("tmo_tx", 32'(tx_count), 32'(exp_tx));
    push(8'h66);
    attempt(0);
    repeat (3) tick();
    chk("after_fail_tx", 32'(tx_count), 32'(exp_tx));

    // Overfill and order
    for (int i = 1; i <= 5; i++) push(8'(i));
    for (int i = 0; i < 4; i++) attempt(0);
    repeat (3) tick();
    chk("order_tx", 32'(tx_count), 32'(exp_tx));

    // ACK and NACK together act as ACK
    push(8'h77);
    attempt(3);
    repeat (3) tick();
    chk("both_tx", 32'(tx_count), 32'(exp_tx));
    chk_flags("both");

    // Randomized traffic
    for (int round = 0; round < 15; round++) begin
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) push(8'($urandom));
      while (q.size() > 0) begin
        r = $urandom_range(0, 9);
        attempt(r < 4 ? 0 : (r < 6 ? 1 : (r < 8 ? 2 : 3)));
      end
      repeat (3) tick();
      chk("rand_tx", 32'(tx_count), 32'(exp_tx));
      chk_flags("rand");
    end

    // Async reset mid-transfer
    push(8'hC1);
    push(8'hC2);
    wait_tx();
    exp_tx++;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_uo", 32'(uo_out), 32'h00);
    chk("midrst_uio", 32'(uio_out), 32'h40);
    q.delete();
    tries     = 0;
    fail_m    = 1'b0;
    seq_m     = 1'b0;
    prev_none = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk_flags("midrst");
    push(8'hAB);
    attempt(0);
    repeat (3) tick();
    chk("final_tx", 32'(tx_count), 32'(exp_tx));
    chk("final_oe", 32'(uio_oe), 32'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_fsm.md
Name: tx_fsm

Overview:
- Tiny Tapeout user block implementing a byte-wide transmit path with stop-and-wait ARQ (automatic repeat request).
- Bytes from `ui_in` are pushed into a small FIFO.
- A transmit FSM presents the head byte on `uo_out` and waits for ACK/NACK from the receiver. It retransmits on NACK or timeout, and drops the byte after a retry limit.
- Top-level wrapper is `tt_um_tx_fsm`, which maps the standard TT pins onto this logic.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- MAX_RETRY, 3, retransmissions allowed after the first send.
- TIMEOUT, 16, cycles spent in WAIT without response before a timeout.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- ena  input  1  TT design-select; ignored by the logic.
- ui_in  input  8  data byte to push.
- uio_in  input  8  bit0 `wr_en` (push strobe), bit1 `ack`, bit2 `nack`; bits 7:3 unused.
- uo_out  output  8  transmit data register.
- uio_out  output  8  bit3 `seq` (optional feature, else 0), bit4 `tx_valid`, bit5 `fifo_full`, bit6 `fifo_empty`, bit7 `fail`; bits 2:0 are 0.
- uio_oe  output  8  constant 8'hF0; bits 7:4 are outputs, bits 3:0 are inputs.
- Note: bit3 is driven on `uio_out` but `uio_oe[3]`=0; `seq` appears at the pin only if the top level overrides `uio_oe[3]`.

Behaviour:
- Reset values:
  - FIFO empty; state IDLE; retry count 0; timeout counter 0.
  - `uo_out`=0; `tx_valid`=0; `fail`=0; `fifo_empty`=1; `fifo_full`=0.
- FIFO push:
  - Occurs when `wr_en`=1 and the FIFO is not full at that clock edge.
  - Push while full is silently dropped.
  - A same-cycle pop does not make room for a push when full.
  - Pointers wrap modulo DEPTH; the count is (log2 DEPTH + 1) bits wide.
  - `fifo_full` and `fifo_empty` are registered flags derived from the count.
- FSM states: IDLE, SEND, WAIT, ERROR.
- IDLE:
  - If FIFO not empty: load head byte into the `uo_out` register and go to SEND.
  - The byte is not popped yet.
- SEND:
  - `tx_valid`=1 for exactly this one cycle.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - `ack`=1: pop the FIFO, clear the retry count, go to IDLE. ACK has priority over NACK when both are high.
  - `nack`=1, or timeout counter = TIMEOUT-1:
    - If retry count < MAX_RETRY: increment it and go to SEND; the same byte is retransmitted and `uo_out` is unchanged.
    - Otherwise go to ERROR.
  - Otherwise the timeout counter increments.
- ERROR (one cycle):
  - Pop (drop) the head byte, clear the retry count, set `fail`, go to IDLE.
- `fail` is sticky and cleared only by reset.
- `ack`/`nack` outside WAIT are ignored.
- `uo_out` holds its last value in IDLE until the next load.
- Latency:
  - A push into an empty FIFO in IDLE: `fifo_empty` falls at edge N, the load happens at N+1, and `tx_valid` is high in the cycle after N+1.
  - One full transmit attempt takes at least 3 cycles.
- Async reset mid-transfer: all state returns to reset values immediately; queued bytes are lost.

Optional Feature:
- Macro: `TX_FSM_SEQ_BIT_EN`.
- When defined:
  - A 1-bit alternating sequence register, reset 0, drives `uio_out[3]`.
  - It toggles whenever a byte leaves the FIFO (ACK pop or ERROR drop) and is constant across retransmissions.
- When undefined: `uio_out[3]`=0 and no register is instantiated.

Decomposition:
- Package `tx_fsm_pkg`: state enum (IDLE, SEND, WAIT, ERROR), `uio` bit-index constants (WR_EN, ACK, NACK, SEQ, TX_VALID, FULL, EMPTY, FAIL), and the `UIO_OE` constant 8'hF0.
- Sub-module `tx_fsm_fifo`:
  - Parameterised synchronous FIFO.
  - Ports: push/pop/din/dout/full/empty; dout is the head byte (first-word fall-through).
- The FSM, counters and pin mapping live in `tx_fsm`.
- `tt_um_tx_fsm` only wires the pins.

Test Plan:
- Reset: assert `rst_n`=0 → `uo_out`=0x00, `uio_out`=0x40, `uio_oe`=0xF0; hold rst_n low for 5 cycles with toggling inputs → outputs unchanged.
- Single byte: push 0xA5, then pulse `ack` in WAIT → `uo_out`=0xA5, exactly one `tx_valid` pulse, `fifo_empty`=1 afterwards, `fail`=0.
- NACK retries: push 0x3C, NACK twice then ACK → three `tx_valid` pulses all with `uo_out`=0x3C, `fail`=0, FIFO empty.
- Timeout and drop: push 0x55 and never respond → retransmit every 16 WAIT cycles, 4 `tx_valid` pulses total, then `fail`=1 and FIFO empty; a following byte 0x66 with ACK still transmits.
- FIFO full and order: push 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back with no ACK → `fifo_full`=1 and 0x05 dropped; ACK each in turn → `uo_out` shows 0x01, 0x02, 0x03, 0x04.
- ACK+NACK same cycle in WAIT → treated as ACK (pop, no retransmit); with `TX_FSM_SEQ_BIT_EN` defined, `seq` toggles 0→1 after that pop.
